// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared types and defaults for the downsampling processor data-memory path
package dsp_pkg;

  // Purpose: state encoding and default geometry for dm_ctrl / dm_ram.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2,
    WRITE   = 2'd3
  } dm_state_t;

  localparam int DM_ADDR_W = 16;
  localparam int DM_DATA_W = 8;
  localparam int DM_RD_LAT = 2;

endpackage

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - single-port synchronous pixel RAM with RD_LAT-stage read pipeline
// Purpose: 2**ADDR_W x DATA_W storage, write-first, contents not reset.
// Ports:
//   i_clk    clock
//   i_we     write enable (commits i_wdata at i_addr on the rising edge)
//   i_addr   byte address, used for both read and write
//   i_wdata  write data
//   o_rdata  read data, valid RD_LAT edges after i_addr is presented
module dm_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_pipe [RD_LAT];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    // Write-first: a same-cycle write is forwarded into the read pipeline.
    r_pipe[0] <= i_we ? i_wdata : r_mem[i_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_rdata = r_pipe[RD_LAT-1];

endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - data-memory access controller: one read or write at a time, ready/err pulses
// Purpose: accepts rd_req/wr_req in IDLE, sequences dm_ram, returns read byte on dm_out.
// Ports:
//   clock     system clock
//   rst       asynchronous active-low reset
//   ar_in     byte address, latched at acceptance
//   dm_in     write data, latched at acceptance
//   rd_req    read request level (sampled in IDLE)
//   wr_req    write request level (sampled in IDLE, wins over rd_req)
//   dm_out    last byte read, held until the next read completes
//   dm_ready  one-cycle completion pulse
//   busy      high whenever the FSM is not in IDLE
//   err       one-cycle pulse per dropped or conflicting request
module dm_ctrl
  import dsp_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W,
  parameter int RD_LAT = DM_RD_LAT
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic [DATA_W-1:0] dm_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] dm_out,
  output logic              dm_ready,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  dm_state_t         r_state;
  logic [2:0]        r_lat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_dm_out;
  logic              r_dm_ready;
  logic              r_busy;
  logic              r_err;

  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  // Write enable comes straight from the state register, so an async reset
  // during WRITE drops it before the commit edge.
  assign w_we = (r_state == WRITE);

  dm_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_ram (
    .i_clk  (clock),
    .i_we   (w_we),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dm_out   <= '0;
      r_dm_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_dm_ready <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wr_req) begin
            r_addr  <= ar_in;
            r_wdata <= dm_in;
            r_state <= WRITE;
            r_busy  <= 1'b1;
            r_err   <= rd_req;  // the simultaneous read is discarded
          end else if (rd_req) begin
            r_addr    <= ar_in;
            r_lat_cnt <= LAT_INIT;
            r_state   <= RD_WAIT;
            r_busy    <= 1'b1;
          end
        end
        RD_WAIT: begin
          r_err <= rd_req | wr_req;
          if (r_lat_cnt == 3'd0) begin
            r_state <= RD_DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        RD_DONE: begin
          r_err      <= rd_req | wr_req;
          r_dm_out   <= w_rdata;
          r_dm_ready <= 1'b1;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
        WRITE: begin
          r_err      <= rd_req | wr_req;
          r_dm_ready <= 1'b1;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dm_out   = r_dm_out;
  assign dm_ready = r_dm_ready;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - self-checking bench for dm_ctrl with a behavioural memory model
module tb_dm_ctrl;
  import dsp_pkg::*;

  localparam int AW = DM_ADDR_W;
  localparam int DW = DM_DATA_W;
  localparam int RL = DM_RD_LAT;

  logic          clock  = 1'b0;
  logic          rst    = 1'b0;
  logic [AW-1:0] ar_in  = '0;
  logic [DW-1:0] dm_in  = '0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [DW-1:0] dm_out;
  logic          dm_ready;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] written_q [$];
  logic [DW-1:0] ref_dm_out = '0;

  dm_ctrl dut (
    .clock   (clock),
    .rst     (rst),
    .ar_in   (ar_in),
    .dm_in   (dm_in),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .dm_out  (dm_out),
    .dm_ready(dm_ready),
    .busy    (busy),
    .err     (err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // One complete access from IDLE; completion is expected 1 edge after acceptance
  // for a write and RL+1 edges for a read.
  task automatic access(input bit is_wr, input bit also_rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit b2b, input string tag);
    int lat;
    int exp_lat;
    bit seen;
    ar_in  = a;
    dm_in  = d;
    wr_req = is_wr;
    rd_req = !is_wr || also_rd;
    tick;
    wr_req = 1'b0;
    rd_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
    end
    n_checks++;
    if (err !== (is_wr && also_rd)) begin
      n_err++;
      $display("FAIL %s err_at_accept: got %b want %b", tag, err, is_wr && also_rd);
    end
    if (is_wr) begin
      ref_mem[a] = d;
      written_q.push_back(a);
      exp_lat = 1;
    end else begin
      if (ref_mem.exists(a)) ref_dm_out = ref_mem[a];
      exp_lat = RL + 1;
    end
    lat  = 1;
    seen = 1'b0;
    tick;
    while (!seen && lat <= 20) begin
      if (dm_ready === 1'b1) seen = 1'b1;
      else begin
        tick;
        lat++;
      end
    end
    n_checks++;
    if (!seen || lat != exp_lat) begin
      n_err++;
      $display("FAIL %s ready_latency: got %0d (seen=%b) want %0d", tag, lat, seen, exp_lat);
    end
    n_checks++;
    if (dm_out !== ref_dm_out) begin
      n_err++;
      $display("FAIL %s dm_out: got %h want %h", tag, dm_out, ref_dm_out);
    end
    if (!b2b) begin
      tick;
      n_checks++;
      if (dm_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle_after: got ready=%b busy=%b err=%b want 0 0 0", tag, dm_ready, busy, err);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick;
    n_checks++;
    if (dm_out !== '0 || dm_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got out=%h ready=%b busy=%b err=%b want 0", dm_out, dm_ready, busy, err);
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    access(1'b1, 1'b0, 16'h0010, 8'hA5, 1'b0, "basic_wr");
    access(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, "basic_rd");
  endtask

  task automatic test_conflict;
    access(1'b1, 1'b1, 16'h0020, 8'h3C, 1'b0, "conflict_wr");
    access(1'b0, 1'b0, 16'h0020, 8'h00, 1'b0, "conflict_rd");
  endtask

  task automatic test_busy_req;
    int pulses = 0;
    int rdy_at = 0;
    ar_in  = 16'h0010;
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    dm_in  = 8'hFF;
    wr_req = 1'b1;
    ref_dm_out = ref_mem[16'h0010];
    for (int i = 1; i <= RL + 1; i++) begin
      tick;
      if (err === 1'b1) pulses++;
      if (dm_ready === 1'b1) rdy_at = i;
    end
    wr_req = 1'b0;
    tick;
    n_checks++;
    if (pulses != RL + 1) begin
      n_err++;
      $display("FAIL busy_req err_pulses: got %0d want %0d", pulses, RL + 1);
    end
    n_checks++;
    if (rdy_at != RL + 1 || dm_out !== ref_dm_out) begin
      n_err++;
      $display("FAIL busy_req read: got at=%0d out=%h want at=%0d out=%h", rdy_at, dm_out, RL + 1, ref_dm_out);
    end
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_req dropped: got err=%b busy=%b want 0 0", err, busy);
    end
    access(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, "busy_req_reread");
  endtask

  task automatic test_addr_change;
    access(1'b1, 1'b0, 16'h0030, 8'h5A, 1'b0, "addr_chg_prep");
    ar_in  = 16'h0010;
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    ar_in  = 16'h0030;
    ref_dm_out = ref_mem[16'h0010];
    repeat (RL + 1) tick;
    n_checks++;
    if (dm_ready !== 1'b1 || dm_out !== ref_dm_out) begin
      n_err++;
      $display("FAIL addr_change: got ready=%b out=%h want 1 %h", dm_ready, dm_out, ref_dm_out);
    end
    tick;
  endtask

  task automatic test_reset_mid_write;
    access(1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, "rstw_prep");
    ar_in  = 16'h0040;
    dm_in  = 8'h77;
    wr_req = 1'b1;
    tick;
    wr_req = 1'b0;
    rst    = 1'b0;
    #1;
    n_checks++;
    if (dm_out !== '0 || dm_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_write outputs: got out=%h ready=%b busy=%b err=%b want 0", dm_out, dm_ready, busy, err);
    end
    tick;
    n_checks++;
    if (dm_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_write ready: got %b want 0", dm_ready);
    end
    rst = 1'b1;
    ref_dm_out = '0;
    tick;
    access(1'b0, 1'b0, 16'h0040, 8'h00, 1'b0, "rstw_read");
  endtask

  task automatic test_boundary;
    access(1'b1, 1'b0, 16'h0000, 8'h11, 1'b0, "bnd_wr_lo");
    access(1'b1, 1'b0, 16'hFFFF, 8'hEE, 1'b0, "bnd_wr_hi");
    access(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, "bnd_rd_lo");
    access(1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b0, "bnd_rd_hi");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      bit            w;
      bit            both;
      bit            b2b;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      w    = (written_q.size() == 0) || ($urandom_range(0, 1) == 1);
      both = w && ($urandom_range(0, 3) == 0);
      b2b  = ($urandom_range(0, 1) == 1);
      d    = DW'($urandom);
      if (w) begin
        if (written_q.size() != 0 && $urandom_range(0, 2) == 0)
          a = written_q[$urandom_range(0, written_q.size() - 1)];
        else
          a = AW'($urandom);
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
      end
      access(w, both, a, d, b2b, $sformatf("rand%0d", i));
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_conflict;
    test_busy_req;
    test_addr_change;
    test_reset_mid_write;
    test_boundary;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
